// File: rtl/imem_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module      : imem_ctrl                                                  |
// | Description : Instruction memory with a byte-stream program loader that  |
// |               holds the core while a load is in flight.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module imem_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_o,
  output logic              cpu_hold,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W-1:0] ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              ld_abort,
  output logic              ld_done,
  output logic              ld_err,
  output logic [DATA_W-1:0] ld_csum
);

  localparam int         c_DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] c_REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_mem [0:c_DEPTH-1];
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [ADDR_W:0]     r_remaining;
  logic [DATA_W-1:0]   r_csum;
  logic                r_err;
  logic                w_accept;
  logic [ADDR_W:0]     w_len_ext;

  // A zero length encodes a full-memory load, hence the extra counter bit.
  assign w_len_ext = {(ld_len == '0), ld_len};
  assign w_accept  = (r_state == S_LOAD) & ld_valid & ~ld_abort;

  always_comb begin
    w_state_nxt = r_state;
    cpu_hold    = 1'b1;
    ld_ready    = 1'b0;
    ld_done     = 1'b0;
    inst_o      = '0;
    case (r_state)
      S_RUN: begin
        cpu_hold = 1'b0;
        inst_o   = r_mem[inst_addr];
        if (ld_start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        if (ld_abort)
          w_state_nxt = S_RUN;
        else if (w_accept && (r_remaining == c_REM_ONE))
          w_state_nxt = S_DONE;
      end
      S_DONE: begin
        ld_done     = 1'b1;
        w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_wr_addr   <= '0;
      r_remaining <= '0;
      r_csum      <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_RUN) && ld_start) begin
        r_wr_addr   <= ld_base;
        r_remaining <= w_len_ext;
        r_csum      <= '0;
        r_err       <= 1'b0;
      end
      if ((r_state == S_LOAD) && ld_abort) r_err <= 1'b1;
      if (w_accept) begin
        r_wr_addr   <= r_wr_addr + 1'b1;
        r_remaining <= r_remaining - c_REM_ONE;
        r_csum      <= r_csum ^ ld_data;
      end
    end
  end

  // Storage is never reset; reset only blocks a write in the same cycle.
  always_ff @(posedge clk) begin
    if (w_accept && !reset) r_mem[r_wr_addr] <= ld_data;
  end

  assign ld_err  = r_err;
  assign ld_csum = r_csum;

endmodule

`default_nettype wire

// File: tb/tb_imem_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_imem_ctrl                                               |
// | Description : Directed self-checking bench for imem_ctrl.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_imem_ctrl;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_o;
  logic              cpu_hold;
  logic              ld_start;
  logic [ADDR_W-1:0] ld_base;
  logic [ADDR_W-1:0] ld_len;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              ld_abort;
  logic              ld_done;
  logic              ld_err;
  logic [DATA_W-1:0] ld_csum;

  int checks;
  int failures;

  imem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .inst_addr(inst_addr),
    .inst_o   (inst_o),
    .cpu_hold (cpu_hold),
    .ld_start (ld_start),
    .ld_base  (ld_base),
    .ld_len   (ld_len),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_abort (ld_abort),
    .ld_done  (ld_done),
    .ld_err   (ld_err),
    .ld_csum  (ld_csum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    inst_addr = a;
    #1;
    chk(tag, {24'h0, inst_o}, {24'h0, exp});
  endtask

  initial begin
    logic [DATA_W-1:0] bytes4 [4];
    logic [DATA_W-1:0] csum_m;
    logic [DATA_W-1:0] d;
    int ready_cnt;
    int early_done;

    checks = 0; failures = 0;
    reset = 1'b1; inst_addr = '0; ld_start = 1'b0; ld_base = '0; ld_len = '0;
    ld_valid = 1'b0; ld_data = '0; ld_abort = 1'b0;
    tick(); tick();
    chk("rst_hold",  {31'h0, cpu_hold}, 32'h0);
    chk("rst_ready", {31'h0, ld_ready}, 32'h0);
    chk("rst_done",  {31'h0, ld_done},  32'h0);
    chk("rst_err",   {31'h0, ld_err},   32'h0);
    chk("rst_csum",  {24'h0, ld_csum},  32'h0);
    reset = 1'b0;
    tick();

    // 4-byte load at base 0
    bytes4[0] = 8'h11; bytes4[1] = 8'h22; bytes4[2] = 8'h33; bytes4[3] = 8'h44;
    ld_start = 1'b1; ld_base = 12'h000; ld_len = 12'd4;
    tick();
    ld_start = 1'b0;
    chk("t1_hold_load", {31'h0, cpu_hold}, 32'h1);
    chk("t1_inst_zero", {24'h0, inst_o},   32'h0);
    ready_cnt = 0;
    ld_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (ld_ready) ready_cnt++;
      ld_data = bytes4[i];
      tick();
    end
    ld_valid = 1'b0;
    chk("t1_ready_cycles", ready_cnt, 32'd4);
    chk("t1_done_pulse", {31'h0, ld_done},  32'h1);
    chk("t1_done_ready", {31'h0, ld_ready}, 32'h0);
    chk("t1_done_hold",  {31'h0, cpu_hold}, 32'h1);
    tick();
    chk("t1_done_end", {31'h0, ld_done},  32'h0);
    chk("t1_run_hold", {31'h0, cpu_hold}, 32'h0);
    chk("t1_csum",     {24'h0, ld_csum},  32'h44);
    rd("t1_mem0", 12'h000, 8'h11);
    rd("t1_mem1", 12'h001, 8'h22);
    rd("t1_mem2", 12'h002, 8'h33);
    rd("t1_mem3", 12'h003, 8'h44);

    // gapped valid, len 2 at 0x21
    ld_start = 1'b1; ld_base = 12'h021; ld_len = 12'd2;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 8'h5A; tick();
    ld_valid = 1'b0; ld_data = 8'hFF; tick();
    chk("t2_gap_done1", {31'h0, ld_done},  32'h0);
    tick();
    chk("t2_gap_done2", {31'h0, ld_done},  32'h0);
    chk("t2_gap_ready", {31'h0, ld_ready}, 32'h1);
    ld_valid = 1'b1; ld_data = 8'hC3; tick();
    ld_valid = 1'b0;
    chk("t2_done",      {31'h0, ld_done},  32'h1);
    chk("t2_hold_done", {31'h0, cpu_hold}, 32'h1);
    tick();
    chk("t2_run_hold",  {31'h0, cpu_hold}, 32'h0);
    chk("t2_csum",      {24'h0, ld_csum},  32'h99);
    rd("t2_mem21", 12'h021, 8'h5A);
    rd("t2_mem22", 12'h022, 8'hC3);

    // valid while not ready is ignored
    ld_valid = 1'b1; ld_data = 8'hEE; tick(); tick();
    ld_valid = 1'b0;
    chk("t2_idle_ready", {31'h0, ld_ready}, 32'h0);
    chk("t2_idle_csum",  {24'h0, ld_csum},  32'h99);
    rd("t2_idle_mem0", 12'h000, 8'h11);

    // wrap across the top of memory
    ld_start = 1'b1; ld_base = 12'hFFE; ld_len = 12'd3;
    tick();
    ld_start = 1'b0; ld_valid = 1'b1;
    ld_data = 8'hA1; tick();
    ld_data = 8'hA2; tick();
    ld_data = 8'hA3; tick();
    ld_valid = 1'b0;
    chk("t3_done", {31'h0, ld_done}, 32'h1);
    tick();
    chk("t3_csum", {24'h0, ld_csum}, 32'hA0);
    rd("t3_memFFE", 12'hFFE, 8'hA1);
    rd("t3_memFFF", 12'hFFF, 8'hA2);
    rd("t3_mem000", 12'h000, 8'hA3);

    // abort coinciding with the 3rd byte
    ld_start = 1'b1; ld_base = 12'h020; ld_len = 12'd4;
    tick();
    ld_start = 1'b0; ld_valid = 1'b1;
    ld_data = 8'hB1; tick();
    ld_data = 8'hB2; tick();
    ld_data = 8'hB3; ld_abort = 1'b1; tick();
    ld_abort = 1'b0; ld_valid = 1'b0;
    chk("t4_run_hold", {31'h0, cpu_hold}, 32'h0);
    chk("t4_err",      {31'h0, ld_err},   32'h1);
    chk("t4_no_done",  {31'h0, ld_done},  32'h0);
    chk("t4_csum",     {24'h0, ld_csum},  32'h03);
    tick();
    chk("t4_no_done2", {31'h0, ld_done},  32'h0);
    rd("t4_mem20", 12'h020, 8'hB1);
    rd("t4_mem21", 12'h021, 8'hB2);
    rd("t4_mem22", 12'h022, 8'hC3);
    // abort outside LOAD has no effect
    ld_abort = 1'b1; tick();
    ld_abort = 1'b0;
    chk("t4_abort_run_err",  {31'h0, ld_err},   32'h1);
    chk("t4_abort_run_hold", {31'h0, cpu_hold}, 32'h0);

    // reset mid-load; new start clears ld_err
    ld_start = 1'b1; ld_base = 12'h030; ld_len = 12'd3;
    tick();
    ld_start = 1'b0;
    chk("t5_err_clear",  {31'h0, ld_err},  32'h0);
    chk("t5_csum_clear", {24'h0, ld_csum}, 32'h0);
    ld_valid = 1'b1; ld_data = 8'hD1; tick();
    chk("t5_csum_1", {24'h0, ld_csum}, 32'hD1);
    reset = 1'b1; ld_data = 8'hD2; tick();
    reset = 1'b0; ld_valid = 1'b0;
    chk("t5_rst_hold",  {31'h0, cpu_hold}, 32'h0);
    chk("t5_rst_csum",  {24'h0, ld_csum},  32'h0);
    chk("t5_rst_ready", {31'h0, ld_ready}, 32'h0);
    chk("t5_rst_done",  {31'h0, ld_done},  32'h0);
    rd("t5_mem30", 12'h030, 8'hD1);

    // full-memory load (len 0) with a stray ld_start mid-load
    ld_start = 1'b1; ld_base = 12'h100; ld_len = 12'd0;
    tick();
    ld_start = 1'b0;
    csum_m = '0; early_done = 0; ready_cnt = 0;
    ld_valid = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      d = 8'(i) ^ 8'h5A;
      ld_data = d;
      csum_m = csum_m ^ d;
      if (ld_done) early_done++;
      if (ld_ready) ready_cnt++;
      if (i == 10) begin
        ld_start = 1'b1; ld_base = 12'h500; ld_len = 12'd1;
      end else begin
        ld_start = 1'b0;
      end
      tick();
    end
    ld_valid = 1'b0; ld_start = 1'b0;
    chk("t6_early_done", early_done, 32'd0);
    chk("t6_ready_cnt",  ready_cnt,  32'd4096);
    chk("t6_done",       {31'h0, ld_done}, 32'h1);
    tick();
    chk("t6_run_hold", {31'h0, cpu_hold}, 32'h0);
    chk("t6_csum",     {24'h0, ld_csum},  {24'h0, csum_m});
    rd("t6_mem100", 12'h100, 8'h5A);
    rd("t6_mem0FF", 12'h0FF, 8'hFF ^ 8'h5A);
    rd("t6_mem505", 12'h505, 8'h05 ^ 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_ctrl.md
IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 Parameter ADDR_W, 12, instruction address width; memory depth is 2^ADDR_W bytes.
REQ-002 Parameter DATA_W, 8, instruction byte width.
REQ-003 The block SHALL have one clock, and reset SHALL be synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 inst_addr  in  ADDR_W  fetch address driven by the fetch unit's PC.
REQ-007 inst_o  out  DATA_W  instruction byte returned to the fetch unit.
REQ-008 cpu_hold  out  1  high: the core SHALL NOT advance fetch.
REQ-009 ld_start  in  1  single-cycle pulse that begins a program load.
REQ-010 ld_base  in  ADDR_W  first write address, sampled with ld_start.
REQ-011 ld_len  in  ADDR_W  byte count, sampled with ld_start; 0 means 2^ADDR_W.
REQ-012 ld_valid  in  1  ld_data holds a byte.
REQ-013 ld_data  in  DATA_W  program byte.
REQ-014 ld_ready  out  1  block accepts a byte this cycle.
REQ-015 ld_abort  in  1  terminates an in-progress load.
REQ-016 ld_done  out  1  single-cycle pulse on load completion.
REQ-017 ld_err  out  1  sticky: last load was aborted.
REQ-018 ld_csum  out  DATA_W  XOR of all bytes accepted in the current or last load.

Function
REQ-019 Storage SHALL be a 2^ADDR_W x DATA_W array with one write port and one asynchronous read port.
REQ-020 FSM states SHALL be RUN, LOAD and DONE.
REQ-021 In RUN, inst_o SHALL equal mem[inst_addr] combinationally, with zero-cycle latency.
REQ-022 In LOAD and DONE, inst_o SHALL be 8'h00.
REQ-023 cpu_hold SHALL be 1 in LOAD and DONE, and 0 in RUN.
REQ-024 RUN -> LOAD on ld_start: wr_addr<=ld_base, remaining<=ld_len (0 -> 2^ADDR_W, so the counter is ADDR_W+1 bits), ld_csum<=0, ld_err<=0.
REQ-025 ld_ready SHALL be 1 exactly when the state is LOAD.
REQ-026 Accept = ld_valid & ld_ready & !ld_abort; on accept: mem[wr_addr]<=ld_data, wr_addr<=wr_addr+1 mod 2^ADDR_W, remaining<=remaining-1, ld_csum<=ld_csum^ld_data.
REQ-027 ld_valid while ld_ready=0 SHALL be ignored, with no write and no state change.
REQ-028 An accept with remaining==1 SHALL move LOAD -> DONE on the next edge.
REQ-029 DONE SHALL last exactly one cycle with ld_done=1, then the FSM SHALL return to RUN.
REQ-030 ld_abort in LOAD SHALL return the FSM to RUN next cycle with ld_err<=1 and no ld_done; abort wins over a simultaneous byte, which is not written.
REQ-031 ld_abort outside LOAD SHALL be ignored.
REQ-032 ld_start in LOAD or DONE SHALL be ignored.
REQ-033 Write addresses SHALL wrap from 2^ADDR_W-1 to 0 mid-load.
REQ-034 Bytes written before an abort or reset SHALL remain in memory.

Reset
REQ-035 On reset: state=RUN, cpu_hold=0, ld_ready=0, ld_done=0, ld_err=0, ld_csum=0, wr_addr=0, remaining=0.
REQ-036 Memory contents SHALL NOT be reset.
REQ-037 Reset during LOAD or DONE SHALL take priority over all inputs; no ld_done is produced.

Verification
REQ-038 Load of 4 bytes: ld_base=0, ld_len=4, data 11,22,33,44 with ld_valid held -> ld_ready 4 cycles; DONE pulse; mem[0..3]=11,22,33,44; ld_csum=44; inst_addr=2 in RUN gives inst_o=33.
REQ-039 Gapped valid: ld_len=2, ld_valid toggles 1,0,0,1 -> exactly 2 writes; ld_done one cycle after the 2nd accept; cpu_hold high through DONE.
REQ-040 Wrap: ld_base=FFE, ld_len=3, data A1,A2,A3 -> mem[FFE]=A1, mem[FFF]=A2, mem[000]=A3.
REQ-041 Abort: ld_len=4, ld_abort coincides with the 3rd byte -> only 2 bytes written; RUN next cycle; ld_err=1; ld_done never pulses; next ld_start clears ld_err.
REQ-042 Reset mid-load: after 1 of 3 bytes, pulse reset -> RUN, ld_csum=0, cpu_hold=0; the first byte remains in memory.
REQ-043 ld_len=0 -> 4096 accepts before ld_done; a 2nd ld_start during LOAD is ignored.
